imem_fetch_ctrl: RTL and testbench
==================================

// Module: imem_fetch_ctrl
// PURPOSE
//  Sequences the 1024x32 instruction memory: owns the program counter and drives the
//  combinational-read IMemory address. Captures each fetched word with its PC into a
//  small fetch buffer and hands instructions to decode over a valid/ready handshake.
//  Supports branch/jump redirect with flush, and halt/resume. Sits between IMemory and decode.
// PARAMETERS
//  ADDR_W    10   PC / IMemory address width (word-addressed)
//  DATA_W    32   instruction width
//  FB_DEPTH  2    fetch buffer entries (power of 2, >=2)
//  RESET_PC  0    PC loaded on reset
// PORTS
//  clk            in   1       clock; all state updates on rising edge
//  rst_n          in   1       asynchronous, active-low reset
//  imem_addr      out  ADDR_W  address to IMemory ProgCounter (= current PC)
//  imem_data      in   DATA_W  IMemory DataOut; valid in the same cycle as imem_addr
//  instr_valid    out  1       buffer head holds an instruction for decode
//  instr_ready    in   1       decode accepts head this cycle
//  instr_data     out  DATA_W  head instruction
//  instr_pc       out  ADDR_W  PC of head instruction
//  redirect_valid in   1       one-cycle pulse: branch/jump taken
//  redirect_pc    in   ADDR_W  new PC on redirect
//  halt_req       in   1       level or pulse: stop fetching
//  resume         in   1       pulse: restart fetching from current PC
//  halted         out  1       state == HALT
// BEHAVIOUR
//  Reset (async assert, sync deassert at edge): pc=RESET_PC, buffer empty, state=FETCH;
//   outputs: instr_valid=0, instr_data=0, instr_pc=0, halted=0, imem_addr=RESET_PC.
//  States: FETCH, HALT (encoded in shared package).
//   FETCH->HALT: halt_req=1 at edge. HALT->FETCH: resume=1 and halt_req=0 at edge.
//   halt_req and resume both high: halt_req wins (stay/enter HALT).
//  push = (state==FETCH) && !redirect_valid && (count<FB_DEPTH || pop); pushes
//   {imem_data, pc} at the edge and pc <= pc+1. Zero extra latency: word at PC N enters
//   buffer at the edge ending the cycle imem_addr==N; instr_valid earliest next cycle.
//  pop = instr_valid && instr_ready; head transferred and removed.
//  Full and pop same cycle: push still occurs; count unchanged.
//  PC wrap: pc+1 is modulo 2^ADDR_W (1023 -> 0), no error flag.
//  Redirect (highest priority, any state): pc <= redirect_pc; buffer flushed (count=0,
//   instr_valid=0 next cycle); no push that cycle. A pop in the same cycle counts as a
//   completed transfer (decode owns that instruction) before the flush.
//  Redirect in HALT: pc updated, stays HALT. halt_req in same cycle as push: push
//   completes (word at current PC enters buffer), then HALT.
//  HALT: no pushes, pc frozen, buffer drains normally via pops; instr_valid stays
//   high while entries remain. imem_addr always equals pc.
//  instr_data/instr_pc hold stable while instr_valid && !instr_ready (no redirect).
//  Reset mid-operation: immediate return to reset values; in-flight entries discarded.
// STRUCTURE
//  Shared package: ADDR_W/DATA_W defaults, fetch state enum (FETCH=1'b0, HALT=1'b1),
//   fetch-buffer entry struct {data, pc}.
//  Sub-module fetch_fifo: synchronous FIFO (DEPTH, WIDTH=DATA_W+ADDR_W) with push/pop,
//   flush, count, full/empty; same async active-low reset. Top holds pc, FSM, control.
// TESTING
//  1 Reset, mem[k]=k+0x100, ready=1 -> instr_pc 0,1,2,3 with data 0x100.. on
//    consecutive cycles, instr_valid first high 1 cycle after reset release.
//  2 ready=0 for 5 cycles -> count reaches 2, pc stops at 2, head pc=0 data stable;
//    ready=1 -> stream resumes 0,1,2,3 with no gap or duplicate.
//  3 redirect_pc=0x200 while head pc=5 with ready=1 -> pc 5 accepted, next instr_valid
//    low 1 cycle, then instr_pc=0x200, 0x201.
//  4 redirect_pc=1022, ready=1 -> instr_pc 1022, 1023, 0, 1 (wrap).
//  5 halt_req with 2 entries buffered, ready=1 -> both drain, halted=1, imem_addr frozen;
//    resume -> fetch continues at next PC; redirect during HALT to 0x10 -> resume fetches 0x10.
//  6 Assert rst_n=0 mid-stream with buffer full -> instr_valid=0 and imem_addr=RESET_PC
//    immediately (asynchronously); after release stream restarts from RESET_PC.

Source files
------------

// File: rtl/imem_fetch_ctrl_pkg.sv
// Shared types for the instruction-fetch controller: default widths, fetch FSM
// encoding and the fetch-buffer entry layout.
package imem_fetch_ctrl_pkg;

  localparam int ADDR_W_DEF   = 10;
  localparam int DATA_W_DEF   = 32;
  localparam int FB_DEPTH_DEF = 2;

  typedef enum logic {
    FETCH = 1'b0,
    HALT  = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [DATA_W_DEF-1:0] data;
    logic [ADDR_W_DEF-1:0] pc;
  } fb_entry_t;

endpackage

// File: rtl/imem_fetch_ctrl_fetch_fifo.sv
// Small synchronous FIFO holding fetched {data, pc} entries. Flush empties it
// in one cycle; push is accepted when not full or when a pop frees a slot.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 42,
  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW   = PW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage needs no reset: reads are only meaningful while count is nonzero.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Instruction fetch controller: owns the PC, drives the combinational IMemory
// address, buffers fetched words and hands them to decode; redirect and halt/resume.
module imem_fetch_ctrl
  import imem_fetch_ctrl_pkg::*;
#(
  parameter int          ADDR_W   = ADDR_W_DEF,
  parameter int          DATA_W   = DATA_W_DEF,
  parameter int          FB_DEPTH = FB_DEPTH_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_data,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] instr_data,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              halt_req,
  input  logic              resume,
  output logic              halted
);

  localparam int EW = DATA_W + ADDR_W;
  localparam int CW = $clog2(FB_DEPTH) + 1;

  fetch_state_e      state_q;
  fetch_state_e      state_d;
  logic [ADDR_W-1:0] pc_q;
  logic              fetch_en;
  logic              push;
  logic              pop;
  logic [EW-1:0]     head;
  logic [CW-1:0]     fb_count;
  logic              fb_full;
  logic              fb_empty;

  // Decode handshake: an entry moves to decode on any edge where instr_valid and
  // instr_ready are both high; head data/pc hold while valid is high and ready low.
  assign instr_valid = !fb_empty;
  assign pop         = instr_valid && instr_ready;
  assign push        = fetch_en && !redirect_valid && (!fb_full || pop);
  assign imem_addr   = pc_q;
  assign instr_data  = instr_valid ? head[EW-1:ADDR_W] : '0;
  assign instr_pc    = instr_valid ? head[ADDR_W-1:0]  : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= FETCH;
    else        state_q <= state_d;
  end

  // halt_req dominates resume; redirect never changes the state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:   if (halt_req) state_d = HALT;
      HALT:    if (resume && !halt_req) state_d = FETCH;
      default: state_d = FETCH;
    endcase
  end

  always_comb begin
    fetch_en = (state_q == FETCH);
    halted   = (state_q == HALT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              pc_q <= RESET_PC;
    else if (redirect_valid) pc_q <= redirect_pc;
    else if (push)           pc_q <= pc_q + ADDR_W'(1);
  end

  fetch_fifo #(
    .DEPTH (FB_DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .wdata ({imem_data, pc_q}),
    .rdata (head),
    .count (fb_count),
    .full  (fb_full),
    .empty (fb_empty)
  );

  always_ff @(posedge clk) begin
    if (rst_n) assert (fb_empty == (fb_count == '0));
  end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Bench for imem_fetch_ctrl: directed sequences with a scoreboard of expected
// {data, pc} transfers checked by an independent monitor at each handshake.
module tb_imem_fetch_ctrl;
  import imem_fetch_ctrl_pkg::*;

  localparam int AW = 10;
  localparam int DW = 32;
  localparam int EW = $bits(fb_entry_t);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] imem_addr;
  logic [DW-1:0] imem_data;
  logic          instr_valid;
  logic          instr_ready = 1'b0;
  logic [DW-1:0] instr_data;
  logic [AW-1:0] instr_pc;
  logic          redirect_valid = 1'b0;
  logic [AW-1:0] redirect_pc = '0;
  logic          halt_req = 1'b0;
  logic          resume = 1'b0;
  logic          halted;

  int checks = 0;
  int errors = 0;
  logic [EW-1:0] exp_q[$];

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  // IMemory model: mem[k] = k + 0x100
  assign imem_data = 32'(imem_addr) + 32'h100;

  imem_fetch_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr_data     (instr_data),
    .instr_pc       (instr_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt_req       (halt_req),
    .resume         (resume),
    .halted         (halted)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_pc(input logic [AW-1:0] pc);
    fb_entry_t e;
    e.pc   = pc;
    e.data = 32'(pc) + 32'h100;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    rst_n          = 1'b0;
    instr_ready    = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    halt_req       = 1'b0;
    resume         = 1'b0;
    repeat (2) tick();
    check("rst_valid",  64'(instr_valid), 64'd0);
    check("rst_data",   64'(instr_data),  64'd0);
    check("rst_pc",     64'(instr_pc),    64'd0);
    check("rst_halted", 64'(halted),      64'd0);
    check("rst_addr",   64'(imem_addr),   64'd0);
    rst_n = 1'b1;
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (rst_n && instr_valid && instr_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_xfer: got pc 0x%0h data 0x%0h expected no transfer",
                 instr_pc, instr_data);
      end else begin
        fb_entry_t e;
        e = exp_q.pop_front();
        check("xfer_pc",   64'(instr_pc),   64'(e.pc));
        check("xfer_data", 64'(instr_data), 64'(e.data));
      end
    end
  end

  initial begin
    // 1: streaming from reset
    do_reset();
    instr_ready = 1'b1;
    check("t1_valid_c0", 64'(instr_valid), 64'd0);
    for (int i = 0; i < 4; i++) expect_pc(AW'(i));
    tick();
    check("t1_valid_c1", 64'(instr_valid), 64'd1);
    repeat (4) tick();
    instr_ready = 1'b0;

    // 2: backpressure fills the buffer, then the stream resumes
    do_reset();
    repeat (5) tick();
    check("t2_addr_stall", 64'(imem_addr),   64'd2);
    check("t2_valid",      64'(instr_valid), 64'd1);
    check("t2_head_pc",    64'(instr_pc),    64'd0);
    check("t2_head_data",  64'(instr_data),  64'h100);
    instr_ready = 1'b1;
    for (int i = 0; i < 5; i++) expect_pc(AW'(i));
    repeat (5) tick();

    // 3: redirect while head pc=5 is being accepted
    check("t3_head_pc", 64'(instr_pc), 64'd5);
    expect_pc(AW'(5));
    redirect_valid = 1'b1;
    redirect_pc    = AW'(10'h200);
    tick();
    redirect_valid = 1'b0;
    check("t3_flush_valid", 64'(instr_valid), 64'd0);
    check("t3_addr",        64'(imem_addr),   64'h200);
    expect_pc(AW'(10'h200));
    expect_pc(AW'(10'h201));
    repeat (3) tick();
    instr_ready = 1'b0;

    // 4: PC wraps 1023 -> 0
    redirect_valid = 1'b1;
    redirect_pc    = AW'(1022);
    tick();
    redirect_valid = 1'b0;
    instr_ready    = 1'b1;
    expect_pc(AW'(1022));
    expect_pc(AW'(1023));
    expect_pc(AW'(0));
    expect_pc(AW'(1));
    repeat (5) tick();
    instr_ready = 1'b0;

    // 5: halt with a full buffer, drain, resume, redirect while halted
    tick();
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    check("t5_halted",     64'(halted),    64'd1);
    check("t5_addr_halt",  64'(imem_addr), 64'd4);
    instr_ready = 1'b1;
    expect_pc(AW'(2));
    expect_pc(AW'(3));
    repeat (2) tick();
    check("t5_drained",    64'(instr_valid), 64'd0);
    check("t5_addr_frozen", 64'(imem_addr),  64'd4);
    check("t5_still_halt", 64'(halted),      64'd1);
    resume = 1'b1;
    tick();
    resume = 1'b0;
    check("t5_resumed", 64'(halted), 64'd0);
    expect_pc(AW'(4));
    expect_pc(AW'(5));
    repeat (3) tick();
    expect_pc(AW'(6));
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    check("t5_halt2",      64'(halted),    64'd1);
    check("t5_addr_halt2", 64'(imem_addr), 64'd8);
    expect_pc(AW'(7));
    redirect_valid = 1'b1;
    redirect_pc    = AW'(10'h10);
    tick();
    redirect_valid = 1'b0;
    check("t5_redir_halted", 64'(halted),      64'd1);
    check("t5_redir_addr",   64'(imem_addr),   64'h10);
    check("t5_redir_valid",  64'(instr_valid), 64'd0);
    resume = 1'b1;
    tick();
    resume = 1'b0;
    expect_pc(AW'(10'h10));
    expect_pc(AW'(10'h11));
    repeat (3) tick();
    instr_ready = 1'b0;

    // 6: asynchronous reset with the buffer full
    tick();
    check("t6_full_valid", 64'(instr_valid), 64'd1);
    check("t6_addr",       64'(imem_addr),   64'h14);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_async_valid",  64'(instr_valid), 64'd0);
    check("t6_async_addr",   64'(imem_addr),   64'd0);
    check("t6_async_pc",     64'(instr_pc),    64'd0);
    check("t6_async_data",   64'(instr_data),  64'd0);
    check("t6_async_halted", 64'(halted),      64'd0);
    do_reset();
    instr_ready = 1'b1;
    for (int i = 0; i < 3; i++) expect_pc(AW'(i));
    repeat (4) tick();
    instr_ready = 1'b0;

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
